// File: rtl/alarm_qsys_btn_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_qsys_btn_ctrl
//
// Avalon-MM slave button controller for the alarm clock UI. It takes the four
// raw KEY pins, synchronizes and debounces them, and turns the clean levels
// into press, long-press and auto-repeat events. The events are latched in a
// write-1-to-clear capture register and drive a maskable level interrupt.
//
// Register map (word addresses):
//   0 RO  : [3:0] debounced button state, [7:4] long-press flags
//   1 RW  : [0] auto-repeat enable
//   2 RW  : [3:0] interrupt mask
//   3 W1C : [3:0] press events, [7:4] hold/repeat events
//
// Ports:
//   clk        in   1   system clock
//   reset_n    in   1   asynchronous active-low reset
//   address    in   2   register select
//   chipselect in   1   slave select
//   write_n    in   1   active-low write strobe
//   writedata  in  32   write data
//   readdata   out 32   registered read data (one clock of latency)
//   irq        out  1   level interrupt, any unmasked pending event
//   in_port    in   4   raw button pins
// -----------------------------------------------------------------------------
module alarm_qsys_btn_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int DB_TICKS     = 10,
    parameter int HOLD_TICKS   = 1000,
    parameter int REPEAT_TICKS = 250,
    parameter bit INVERT       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic [3:0]  in_port
);

    localparam int TW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW   = $clog2(DB_TICKS + 1);
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG,
        ST_REPEAT
    } holdState_t;

    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [TW-1:0] r_tickCnt;
    logic          w_tick;
    logic [3:0]    w_stable;
    logic [3:0]    r_stableD;
    logic [3:0]    w_stableRise;
    logic [3:0]    w_long;
    logic [3:0]    w_holdSet;
    logic          r_ctrl;
    logic [3:0]    r_mask;
    logic [3:0]    r_evPress;
    logic [3:0]    r_evHold;
    logic          w_wrEn;
    logic [3:0]    w_pressClr;
    logic [3:0]    w_holdClr;
    logic [31:0]   w_readMux;
    logic          w_unusedBits;

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign w_raw = in_port ^ {4{INVERT}};

    // Upper write data bits have no register behind them.
    assign w_unusedBits = &{1'b0, writedata[31:8]};

    // Two-flop synchronizer; resetting to 0 means buttons start released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler shared by the debouncers and hold timers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt == TICK_LAST) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    assign w_tick = (r_tickCnt == TICK_LAST);

    // Delayed copy of the debounced state, used for edge detection so that a
    // press shows up in the capture register one cycle after stable rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stableD <= 4'b0;
        end else begin
            r_stableD <= w_stable;
        end
    end

    assign w_stableRise = w_stable & ~r_stableD;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [DW-1:0] r_dcnt;
        logic          r_stableBit;
        holdState_t    r_state;
        holdState_t    w_nextState;
        logic [HW-1:0] r_hcnt;
        logic          r_longBit;
        logic          w_holdDone;
        logic          w_repeatDone;

        // Debouncer: any tick where the synchronized level agrees with the
        // accepted level restarts the persistence count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_dcnt      <= '0;
                r_stableBit <= 1'b0;
            end else if (r_sync2[i] == r_stableBit) begin
                r_dcnt <= '0;
            end else if (w_tick) begin
                if (r_dcnt == DB_LAST) begin
                    r_stableBit <= r_sync2[i];
                    r_dcnt      <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end

        // Hold FSM state register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_nextState;
            end
        end

        // Hold FSM next state; a release pulls every state back to IDLE.
        always_comb begin
            w_nextState = r_state;
            if (!r_stableBit) begin
                w_nextState = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_stableRise[i]) begin
                            w_nextState = ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (w_tick && (r_hcnt == HOLD_LAST)) begin
                            w_nextState = r_ctrl ? ST_REPEAT : ST_LONG;
                        end
                    end
                    ST_LONG: begin
                        if (r_ctrl) begin
                            w_nextState = ST_REPEAT;
                        end
                    end
                    ST_REPEAT: begin
                        if (!r_ctrl) begin
                            w_nextState = ST_LONG;
                        end
                    end
                    default: w_nextState = ST_IDLE;
                endcase
            end
        end

        // Hold FSM outputs. A repeat only fires while repeat stays enabled,
        // because dropping ctrl moves the FSM to LONG in the same cycle.
        always_comb begin
            w_holdDone   = 1'b0;
            w_repeatDone = 1'b0;
            if (r_stableBit && w_tick) begin
                if ((r_state == ST_HELD) && (r_hcnt == HOLD_LAST)) begin
                    w_holdDone = 1'b1;
                end
                if ((r_state == ST_REPEAT) && r_ctrl && (r_hcnt == REPEAT_LAST)) begin
                    w_repeatDone = 1'b1;
                end
            end
        end

        // Hold tick counter restarts on every state change and on each
        // repeat; the long flag follows the held button.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_hcnt    <= '0;
                r_longBit <= 1'b0;
            end else begin
                if ((w_nextState != r_state) || w_repeatDone) begin
                    r_hcnt <= '0;
                end else if (w_tick && ((r_state == ST_HELD) || (r_state == ST_REPEAT))) begin
                    r_hcnt <= r_hcnt + 1'b1;
                end

                if (!r_stableBit) begin
                    r_longBit <= 1'b0;
                end else if (w_holdDone) begin
                    r_longBit <= 1'b1;
                end
            end
        end

        assign w_stable[i]  = r_stableBit;
        assign w_long[i]    = r_longBit;
        assign w_holdSet[i] = w_holdDone | w_repeatDone;
    end

    assign w_wrEn     = chipselect & ~write_n;
    assign w_pressClr = (w_wrEn && (address == 2'd3)) ? writedata[3:0] : 4'b0;
    assign w_holdClr  = (w_wrEn && (address == 2'd3)) ? writedata[7:4] : 4'b0;

    // Control and mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= 1'b0;
            r_mask <= 4'b0;
        end else if (w_wrEn) begin
            if (address == 2'd1) begin
                r_ctrl <= writedata[0];
            end
            if (address == 2'd2) begin
                r_mask <= writedata[3:0];
            end
        end
    end

    // Capture register: a new event in the same cycle as its clear wins, so
    // software can never lose an event it has not seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evPress <= 4'b0;
            r_evHold  <= 4'b0;
        end else begin
            r_evPress <= (r_evPress & ~w_pressClr) | w_stableRise;
            r_evHold  <= (r_evHold & ~w_holdClr) | w_holdSet;
        end
    end

    // Read mux; sampled every clock regardless of chipselect.
    always_comb begin
        w_readMux = 32'd0;
        case (address)
            2'd0:    w_readMux = {24'd0, w_long, w_stable};
            2'd1:    w_readMux = {31'd0, r_ctrl};
            2'd2:    w_readMux = {28'd0, r_mask};
            2'd3:    w_readMux = {24'd0, r_evHold, r_evPress};
            default: w_readMux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= w_readMux;
        end
    end

    assign irq = |((r_evPress | r_evHold) & r_mask);

endmodule

// File: tb/tb_alarm_qsys_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_qsys_btn_ctrl
//
// Directed bench for the button controller, built with a 4-clock tick,
// 3-tick debounce, 5-tick hold and 2-tick repeat. The bench keeps its own
// count of clock edges since reset release; with the prescaler starting at
// zero, ticks are consumed on edges whose count is a multiple of 4, which
// lets every expected value below be placed on an exact edge.
// -----------------------------------------------------------------------------
module tb_alarm_qsys_btn_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  in_port;

    int checks;
    int errors;
    int cyc;

    alarm_qsys_btn_ctrl #(
        .TICK_DIV    (4),
        .DB_TICKS    (3),
        .HOLD_TICKS  (5),
        .REPEAT_TICKS(2),
        .INVERT      (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .in_port   (in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Safety net in case a wait never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want summary");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic stepTo(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic alignTick(output int r);
        do @(negedge clk); while ((cyc % 4) != 0);
        r = cyc;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Returns the register state as it stood right after edge 'target'.
    task automatic peek(input logic [1:0] a, input int target, output logic [31:0] d);
        stepTo(target);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n    = 1'b0;
        in_port    = 4'hF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_readdata: got %h want %h", readdata, 32'd0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b want 0", irq);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), cyc, rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_addr%0d: got %h want %h", a, rd, 32'd0);
            end
        end
    endtask

    task automatic test_debounce;
        logic [31:0] rd;
        int r;
        alignTick(r);
        in_port[0] = 1'b0;
        repeat (4) @(negedge clk);
        in_port[0] = 1'b1;
        peek(2'd0, r + 16, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL glitch_stable: got %h want %h", rd, 32'h0);
        end
        peek(2'd3, r + 17, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL glitch_event: got %h want %h", rd, 32'h0);
        end

        alignTick(r);
        in_port[0] = 1'b0;
        peek(2'd0, r + 11, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL db_early: got %h want %h", rd, 32'h0);
        end
        peek(2'd0, r + 12, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL db_stable: got %h want %h", rd, 32'h1);
        end
        peek(2'd3, r + 13, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL press_event: got %h want %h", rd, 32'h1);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_masked: got %b want 0", irq);
        end
        in_port[0] = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        int r;
        busWrite(2'd2, 32'h1);
        peek(2'd2, cyc, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mask_read: got %h want %h", rd, 32'h1);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_on: got %b want 1", irq);
        end
        busWrite(2'd3, 32'h1);
        peek(2'd3, cyc, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL w1c_clear: got %h want %h", rd, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_off: got %b want 0", irq);
        end

        alignTick(r);
        in_port[0] = 1'b0;
        stepTo(r + 12);
        busWrite(2'd3, 32'h1);
        peek(2'd3, cyc, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL w1c_vs_set: got %h want %h", rd, 32'h1);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_again: got %b want 1", irq);
        end
        in_port[0] = 1'b1;
        repeat (24) @(negedge clk);
        busWrite(2'd3, 32'h1);
        peek(2'd3, cyc, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL w1c_final: got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_long_press;
        logic [31:0] rd;
        int r;
        int c;
        alignTick(r);
        in_port[2] = 1'b0;
        peek(2'd3, r + 31, rd);
        checks++;
        if (rd !== 32'h04) begin
            errors++;
            $display("[TB] FAIL long_before_hold: got %h want %h", rd, 32'h04);
        end
        busWrite(2'd3, 32'h04);
        peek(2'd3, r + 33, rd);
        checks++;
        if (rd !== 32'h40) begin
            errors++;
            $display("[TB] FAIL long_event: got %h want %h", rd, 32'h40);
        end
        peek(2'd0, r + 34, rd);
        checks++;
        if (rd !== 32'h44) begin
            errors++;
            $display("[TB] FAIL long_status: got %h want %h", rd, 32'h44);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_irq_masked: got %b want 0", irq);
        end
        peek(2'd3, r + 60, rd);
        checks++;
        if (rd !== 32'h40) begin
            errors++;
            $display("[TB] FAIL long_no_repeat: got %h want %h", rd, 32'h40);
        end
        c = cyc;
        in_port[2] = 1'b1;
        peek(2'd0, c + 20, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL long_release: got %h want %h", rd, 32'h0);
        end
        peek(2'd3, c + 21, rd);
        checks++;
        if (rd !== 32'h40) begin
            errors++;
            $display("[TB] FAIL no_release_event: got %h want %h", rd, 32'h40);
        end
        busWrite(2'd3, 32'h40);
        peek(2'd3, cyc, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL long_cleared: got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_repeat;
        logic [31:0] rd;
        int r;
        int c;
        busWrite(2'd1, 32'h1);
        peek(2'd1, cyc, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL ctrl_read: got %h want %h", rd, 32'h1);
        end
        alignTick(r);
        in_port[1] = 1'b0;
        peek(2'd3, r + 31, rd);
        checks++;
        if (rd !== 32'h02) begin
            errors++;
            $display("[TB] FAIL rep_before_hold: got %h want %h", rd, 32'h02);
        end
        busWrite(2'd3, 32'h02);
        peek(2'd3, r + 33, rd);
        checks++;
        if (rd !== 32'h20) begin
            errors++;
            $display("[TB] FAIL rep_first_hold: got %h want %h", rd, 32'h20);
        end
        peek(2'd0, r + 34, rd);
        checks++;
        if (rd !== 32'h22) begin
            errors++;
            $display("[TB] FAIL rep_status: got %h want %h", rd, 32'h22);
        end
        busWrite(2'd3, 32'h20);
        peek(2'd3, r + 39, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rep_gap1: got %h want %h", rd, 32'h0);
        end
        peek(2'd3, r + 40, rd);
        checks++;
        if (rd !== 32'h20) begin
            errors++;
            $display("[TB] FAIL rep_fire1: got %h want %h", rd, 32'h20);
        end
        busWrite(2'd3, 32'h20);
        peek(2'd3, r + 47, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rep_gap2: got %h want %h", rd, 32'h0);
        end
        peek(2'd3, r + 48, rd);
        checks++;
        if (rd !== 32'h20) begin
            errors++;
            $display("[TB] FAIL rep_fire2: got %h want %h", rd, 32'h20);
        end
        busWrite(2'd1, 32'h0);
        busWrite(2'd3, 32'h20);
        peek(2'd3, r + 64, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rep_stopped: got %h want %h", rd, 32'h0);
        end
        peek(2'd0, r + 65, rd);
        checks++;
        if (rd !== 32'h22) begin
            errors++;
            $display("[TB] FAIL rep_long_kept: got %h want %h", rd, 32'h22);
        end
        c = cyc;
        in_port[1] = 1'b1;
        peek(2'd0, c + 20, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rep_release: got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_reset_mid_press;
        logic [31:0] rd;
        int r;
        busWrite(2'd1, 32'h1);
        alignTick(r);
        in_port[3] = 1'b0;
        stepTo(r + 44);
        busWrite(2'd2, 32'hF);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_irq: got %b want 1", irq);
        end
        peek(2'd0, cyc, rd);
        checks++;
        if (rd !== 32'h88) begin
            errors++;
            $display("[TB] FAIL pre_reset_status: got %h want %h", rd, 32'h88);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_readdata: got %h want %h", readdata, 32'd0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_irq: got %b want 0", irq);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        peek(2'd3, 12, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_early: got %h want %h", rd, 32'h0);
        end
        peek(2'd3, 13, rd);
        checks++;
        if (rd !== 32'h08) begin
            errors++;
            $display("[TB] FAIL post_reset_press: got %h want %h", rd, 32'h08);
        end
        peek(2'd0, 14, rd);
        checks++;
        if (rd !== 32'h08) begin
            errors++;
            $display("[TB] FAIL post_reset_status: got %h want %h", rd, 32'h08);
        end
        peek(2'd1, 15, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_ctrl: got %h want %h", rd, 32'h0);
        end
        peek(2'd2, 16, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_mask: got %h want %h", rd, 32'h0);
        end
        peek(2'd3, 31, rd);
        checks++;
        if (rd !== 32'h08) begin
            errors++;
            $display("[TB] FAIL post_reset_no_hold: got %h want %h", rd, 32'h08);
        end
        peek(2'd3, 32, rd);
        checks++;
        if (rd !== 32'h88) begin
            errors++;
            $display("[TB] FAIL post_reset_hold: got %h want %h", rd, 32'h88);
        end
        in_port[3] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_debounce();
        test_irq();
        test_long_press();
        test_repeat();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
